// File: rtl/pwm_deserializer_pkg.sv
// Shared constants for the PWM link: state encoding, window derivation, duty width.
// Imported by both the PWM generator and the deserializer.
package pwm_deserializer_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DUTY_W   = 7;
  localparam int DUTY_MAX = (1 << DUTY_W) - 1;

  function automatic int window_cycles(input int sys_freq, input int pulse_freq);
    return sys_freq / pulse_freq;
  endfunction

  function automatic int timeout_cycles(input int sys_freq, input int pulse_freq);
    return 2 * window_cycles(sys_freq, pulse_freq);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a third flop for single-cycle rise/fall strobes.
// Edges are suppressed until the pipeline holds real samples after reset.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       s_d;
  logic [1:0] fill;
  logic       primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s_d  <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1  <= async_in;
      s2  <= s1;
      s_d <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // a line already high at reset release must not look like a rise
  assign primed = (fill == 2'd3);
  assign rise   = primed & s2 & ~s_d;
  assign fall   = primed & ~s2 & s_d;

endmodule

// File: rtl/pwm_deserializer.sv
// PWM receiver: measures high time and period in clk cycles, reports per pulse.
// Timeouts report a stuck line every TIMEOUT cycles.
module pwm_deserializer
  import pwm_deserializer_pkg::*;
#(
  parameter  int PULSE_FREQ = 1,
  parameter  int SYS_FREQ   = 100,
  parameter  int TOL        = 2,
  localparam int WINDOW     = window_cycles(SYS_FREQ, PULSE_FREQ),
  localparam int TIMEOUT    = timeout_cycles(SYS_FREQ, PULSE_FREQ),
  localparam int CNT_BITS   = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [DUTY_W-1:0]   duty_cycle,
  output logic [CNT_BITS-1:0] period,
  output logic                valid,
  output logic                period_err,
  output logic                stuck
);

  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] TMO = CNT_BITS'(TIMEOUT);
  localparam logic [DUTY_W-1:0] DUTY_WIN =
    DUTY_W'((WINDOW > DUTY_MAX) ? DUTY_MAX : WINDOW);

  logic rise;
  logic fall;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pwm_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_t              state, nxt_state;
  logic [CNT_BITS-1:0] hi_cnt, nxt_hi;
  logic [CNT_BITS-1:0] per_cnt, nxt_per;
  logic [CNT_BITS-1:0] hi_inc, per_inc;
  logic                timeout;
  logic                off_tol;

  logic                rpt;
  logic [DUTY_W-1:0]   rpt_duty;
  logic [CNT_BITS-1:0] rpt_per;
  logic                rpt_err;
  logic                rpt_stuck;

  assign timeout = (state != SYNC) && (per_cnt == TMO);
  assign hi_inc  = (hi_cnt == TMO) ? hi_cnt : hi_cnt + ONE;
  assign per_inc = (per_cnt == TMO) ? per_cnt : per_cnt + ONE;
  assign off_tol = (int'(per_cnt) > WINDOW + TOL) ||
                   (int'(per_cnt) < WINDOW - TOL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SYNC;
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      state   <= nxt_state;
      hi_cnt  <= nxt_hi;
      per_cnt <= nxt_per;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_hi    = hi_cnt;
    nxt_per   = per_cnt;
    unique case (state)
      SYNC: begin
        if (rise) begin
          nxt_state = HIGH;
          nxt_hi    = ONE;
          nxt_per   = ONE;
        end
      end
      HIGH: begin
        if (timeout) begin
          nxt_hi  = ONE;
          nxt_per = ONE;
        end else begin
          nxt_per = per_inc;
          if (!fall) nxt_hi = hi_inc;
        end
        if (fall) nxt_state = LOW;
      end
      LOW: begin
        if (rise) begin
          nxt_state = HIGH;
          nxt_hi    = ONE;
          nxt_per   = ONE;
        end else if (timeout) begin
          // a dead-low window carries no high time into the next report
          nxt_hi  = '0;
          nxt_per = ONE;
        end else begin
          nxt_per = per_inc;
        end
      end
      default: nxt_state = SYNC;
    endcase
  end

  always_comb begin
    rpt       = 1'b0;
    rpt_duty  = '0;
    rpt_per   = per_cnt;
    rpt_err   = 1'b0;
    rpt_stuck = 1'b0;
    if (state == LOW && rise) begin
      rpt      = 1'b1;
      rpt_duty = (int'(hi_cnt) > DUTY_MAX) ? DUTY_W'(DUTY_MAX)
                                           : DUTY_W'(hi_cnt);
      rpt_err  = off_tol;
    end else if (timeout) begin
      rpt       = 1'b1;
      rpt_duty  = (state == HIGH) ? DUTY_WIN : '0;
      rpt_per   = TMO;
      rpt_err   = 1'b1;
      rpt_stuck = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_cycle <= '0;
      period     <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= rpt;
      if (rpt) begin
        duty_cycle <= rpt_duty;
        period     <= rpt_per;
        period_err <= rpt_err;
        stuck      <= rpt_stuck;
      end
    end
  end

endmodule

// File: tb/tb_pwm_deserializer.sv
// Self-checking bench for pwm_deserializer: vector table plus hand-written
// timeout, reset and random-phase sequences, checked through a scoreboard.
`timescale 1ns/100ps
module tb_pwm_deserializer;

  logic       clk;
  logic       reset;
  logic       pwm;
  logic [6:0] duty;
  logic [7:0] per;
  logic       valid;
  logic       perr;
  logic       stuck;

  pwm_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm),
    .duty_cycle (duty),
    .period     (per),
    .valid      (valid),
    .period_err (perr),
    .stuck      (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: exact, 1: only stuck flag, 2: duty/period within +-1
  typedef struct {
    int duty;
    int per;
    bit err;
    bit stuck;
    int mode;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    int n;
    int e_duty;
    int e_per;
    bit e_err;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    checks++;
    if (act < exp - 1 || act > exp + 1) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d+-1", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int d, input int p, input bit e,
                              input bit s, input int m);
    exp_t x;
    x.duty = d; x.per = p; x.err = e; x.stuck = s; x.mode = m;
    return x;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got duty=%0d period=%0d, expected none",
                 duty, per);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.mode == 0) begin
          chk("duty", int'(duty), e.duty);
          chk("period", int'(per), e.per);
          chk("period_err", int'(perr), int'(e.err));
          chk("stuck", int'(stuck), int'(e.stuck));
        end else if (e.mode == 1) begin
          chk("stuck_clear", int'(stuck), 0);
        end else begin
          chk_near("duty_near", int'(duty), e.duty);
          chk_near("period_near", int'(per), e.per);
          chk("stuck_rand", int'(stuck), 0);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_period"}, int'(per), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_err"}, int'(perr), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
  endtask

  task automatic do_reset();
    pwm   = 1'b0;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    chk_zero("rst");
    cycles(4);
  endtask

  task automatic run_wave(input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      pwm = 1'b1;
      if (k > 0) sb.push_back(mk(v.e_duty, v.e_per, v.e_err, 1'b0, 0));
      cycles(v.hi);
      pwm = 1'b0;
      cycles(v.lo);
    end
    pwm = 1'b1;
    sb.push_back(mk(v.e_duty, v.e_per, v.e_err, 1'b0, 0));
    cycles(20);
  endtask

  task automatic wait_until(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  vec_t vecs[8];

  initial begin
    realtime t0;
    realtime jr;
    realtime jf;

    vecs[0] = '{30,  70, 3,  30, 100, 1'b0};
    vecs[1] = '{40,  63, 2,  40, 103, 1'b1};
    vecs[2] = '{40,  62, 2,  40, 102, 1'b0};
    vecs[3] = '{40,  58, 2,  40,  98, 1'b0};
    vecs[4] = '{40,  57, 2,  40,  97, 1'b1};
    vecs[5] = '{150, 40, 2, 127, 190, 1'b1};
    vecs[6] = '{1,   99, 2,   1, 100, 1'b0};
    vecs[7] = '{99,   1, 2,  99, 100, 1'b0};

    pwm   = 1'b0;
    reset = 1'b1;
    cycles(3);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_wave(vecs[i]);
    end

    // line dies low after one full period, then a 50/100 waveform returns
    do_reset();
    pwm = 1'b1;
    cycles(30);
    pwm = 1'b0;
    cycles(70);
    pwm = 1'b1;
    sb.push_back(mk(30, 100, 1'b0, 1'b0, 0));
    cycles(30);
    pwm = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back(mk(0, 200, 1'b1, 1'b1, 0));
    cycles(620);
    pwm = 1'b1;
    sb.push_back(mk(0, 0, 1'b0, 1'b0, 1));
    for (int k = 0; k < 3; k++) begin
      cycles(50);
      pwm = 1'b0;
      cycles(50);
      pwm = 1'b1;
      sb.push_back(mk(50, 100, 1'b0, 1'b0, 0));
    end
    cycles(20);

    // line held high
    do_reset();
    pwm = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(mk(100, 200, 1'b1, 1'b1, 0));
    cycles(650);

    // reset for one clock in the middle of a high phase
    do_reset();
    pwm = 1'b1;
    cycles(30);
    pwm = 1'b0;
    cycles(70);
    pwm = 1'b1;
    sb.push_back(mk(30, 100, 1'b0, 1'b0, 0));
    cycles(15);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk_zero("midrst");
    cycles(14);
    pwm = 1'b0;
    cycles(70);
    pwm = 1'b1;
    cycles(30);
    pwm = 1'b0;
    cycles(70);
    pwm = 1'b1;
    sb.push_back(mk(30, 100, 1'b0, 1'b0, 0));
    cycles(20);

    // 25/75 with edges at random phase relative to clk
    do_reset();
    t0 = $realtime + 50.0;
    for (int k = 0; k <= 8; k++) begin
      jr = real'($urandom_range(0, 95)) * 0.1;
      wait_until(t0 + real'(k) * 1000.0 + jr);
      pwm = 1'b1;
      if (k > 0) sb.push_back(mk(25, 100, 1'b0, 1'b0, 2));
      if (k < 8) begin
        jf = real'($urandom_range(0, 95)) * 0.1;
        wait_until(t0 + real'(k) * 1000.0 + 250.0 + jf);
        pwm = 1'b0;
      end
    end
    cycles(20);

    chk("leftover_expected", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
